secuenciador_pixeles: RTL and testbench

Frame-read controller for the RGB565→RGB888 colour-expansion datapath. On a start pulse it walks a WxH RGB565 frame buffer in raster order and issues one read per pixel to a synchronous memory. It expands each 16-bit word to 8/8/8 RGB and presents the pixels as a valid/ready stream with frame and line markers. It sits between the frame-buffer RAM and the display/VGA output stage.

---
 rtl/secuenciador_pixeles_pkg.sv | 39 +++
 rtl/secuenciador_pixeles_fifo.sv | 46 ++++
 rtl/secuenciador_pixeles.sv | 143 ++++++++++++++
 tb/tb_secuenciador_pixeles.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_pixeles_pkg.sv
// Shared video definitions: RGB565 field layout, sequencer FSM states, colour-bar table.
// The colour-bar table is only referenced when TEST_PATTERN_EN is defined.
package pkg_video;

  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    LEER,
    VACIAR,
    FIN
  } estado_t;

  // White, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] BARRAS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  typedef struct packed {
    logic [15:0] dato;
    logic        sof;
    logic        eol;
    logic        eof;
  } entrada_t;

  // Replicate the top bits of each field into the vacated low bits.
  function automatic logic [23:0] expandir(input logic [15:0] d);
    return {d[R_MSB:R_LSB], d[R_MSB -: 3],
            d[G_MSB:G_LSB], d[G_MSB -: 2],
            d[B_MSB:B_LSB], d[B_MSB -: 3]};
  endfunction

endpackage

// File: rtl/secuenciador_pixeles_fifo.sv
// Two-entry synchronous FIFO holding a pixel word plus its sof/eol/eof tags.
module fifo_pixeles
  import pkg_video::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  entrada_t   din,
  output entrada_t   dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  entrada_t mem [2];
  logic     wr_ptr;
  logic     rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/secuenciador_pixeles.sv
// Raster frame reader: RGB565 memory reads -> RGB888 valid/ready pixel stream with tags.
// Optional colour-bar generator enabled by defining TEST_PATTERN_EN (adds input patron).
module secuenciador_pixeles
  import pkg_video::*;
#(
  parameter int unsigned ANCHO = 320,
  parameter int unsigned ALTO  = 240,
  parameter int unsigned AW    = 17,
  parameter int unsigned BASE  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef TEST_PATTERN_EN
  input  logic          patron,
`endif
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic          sof,
  output logic          eol,
  output logic          eof
);

  localparam int unsigned NPIX = ANCHO * ALTO;
  localparam int unsigned CW   = $clog2(ANCHO);
  localparam int unsigned FW   = (ALTO > 1) ? $clog2(ALTO) : 1;

  estado_t       estado, estado_sig;
  logic [AW-1:0] idx;
  logic          inflight;
  logic [CW-1:0] col;
  logic [FW-1:0] fila;
  logic          arranque, emitir, pop;
  logic [1:0]    ocup;
  logic [2:0]    ocup_tras_pop;
  logic          lleno, vacio;
  entrada_t      cab, nueva;
  logic [23:0]   rgb;

  assign arranque = (estado == IDLE) && start;
  assign pop      = pix_valid && pix_ready;
  // Counting this cycle's pop keeps 1 pixel/clk; buffer space is still guaranteed at capture.
  assign ocup_tras_pop = 3'(ocup) + 3'(inflight) - 3'(pop);

  always_comb begin
    estado_sig = estado;
    emitir     = 1'b0;
    unique case (estado)
      IDLE:   if (start) estado_sig = LEER;
      LEER: begin
        emitir = (ocup_tras_pop < 3'd2);
        if (emitir && (idx == AW'(NPIX - 1))) estado_sig = VACIAR;
      end
      VACIAR: if (pop && cab.eof) estado_sig = FIN;
      FIN:    estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  assign busy     = (estado != IDLE);
  assign done     = (estado == FIN);
  assign mem_addr = AW'(BASE) + idx;

`ifdef TEST_PATTERN_EN
  logic       patron_q;
  logic [2:0] barra;
  assign barra  = 3'(col / CW'(ANCHO / 8));
  assign mem_rd = emitir && !patron_q;
  assign nueva.dato = patron_q ? BARRAS[barra] : mem_data;

  always_ff @(posedge clk) begin
    if (!rst_n)        patron_q <= 1'b0;
    else if (arranque) patron_q <= patron;
  end
`else
  assign mem_rd     = emitir;
  assign nueva.dato = mem_data;
`endif

  assign nueva.sof = (col == '0) && (fila == '0);
  assign nueva.eol = (col == CW'(ANCHO - 1));
  assign nueva.eof = nueva.eol && (fila == FW'(ALTO - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado   <= IDLE;
      idx      <= '0;
      inflight <= 1'b0;
      col      <= '0;
      fila     <= '0;
    end else begin
      estado   <= estado_sig;
      inflight <= emitir;
      if (arranque) begin
        idx  <= '0;
        col  <= '0;
        fila <= '0;
      end else begin
        if (emitir) idx <= idx + AW'(1);
        if (inflight) begin
          if (nueva.eol) begin
            col  <= '0;
            fila <= nueva.eof ? '0 : fila + FW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
      end
    end
  end

  fifo_pixeles u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (nueva),
    .dout  (cab),
    .full  (lleno),
    .empty (vacio),
    .count (ocup)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(lleno && inflight && !pop));

  assign pix_valid = !vacio;
  assign rgb       = expandir(cab.dato);
  assign R   = pix_valid ? rgb[23:16] : '0;
  assign G   = pix_valid ? rgb[15:8]  : '0;
  assign B   = pix_valid ? rgb[7:0]   : '0;
  assign sof = pix_valid && cab.sof;
  assign eol = pix_valid && cab.eol;
  assign eof = pix_valid && cab.eof;

endmodule

// File: tb/tb_secuenciador_pixeles.sv
// Directed bench for secuenciador_pixeles on a 4x2 frame: vector table plus corner sequences.
module tb_secuenciador_pixeles;

  localparam int unsigned ANCHO = 4;
  localparam int unsigned ALTO  = 2;
  localparam int unsigned AW    = 8;
  localparam int unsigned BASE  = 16;
  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pix_ready = 1'b0;
  logic          busy, done, mem_rd, pix_valid, sof, eol, eof;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data = 16'h0;
  logic [7:0]    R, G, B;

  logic [15:0] mem_img [NP];

  typedef struct {
    logic [15:0] w;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        sof;
    logic        eol;
    logic        eof;
  } vec_t;

  vec_t vt [16];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  secuenciador_pixeles #(
    .ANCHO(ANCHO), .ALTO(ALTO), .AW(AW), .BASE(BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef TEST_PATTERN_EN
    .patron    (1'b0),
`endif
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .R         (R),
    .G         (G),
    .B         (B),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof)
  );

  // Synchronous memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem_img[3'(mem_addr - AW'(BASE))];
    else        mem_data <= 16'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_v(input int i, input logic [15:0] w, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b);
    int p;
    p = i % 8;
    vt[i].w   = w;
    vt[i].r   = r;
    vt[i].g   = g;
    vt[i].b   = b;
    vt[i].sof = (p == 0);
    vt[i].eol = (p == 3) || (p == 7);
    vt[i].eof = (p == 7);
  endtask

  // mode 0: ready always high, 1: ready low 5 cycles at pixel 3, 2: random ready
  task automatic run_frame(input int vb, input int mode, input bit poke_busy, input bit poke_done);
    int k = 0;
    int nrd = 0;
    int cyc = 0;
    int first_v = -1;
    int stall = 0;
    bit exp_done = 1'b0;
    bit finished = 1'b0;
    bit hold = 1'b0;
    logic [30:0] held;
    for (int i = 0; i < NP; i++) mem_img[i] = vt[vb + i].w;
    @(negedge clk);
    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    while (!finished && cyc < 100) begin
      cyc++;
      start = 1'b0;
      if (mode == 1 && k == 3 && stall < 5) begin
        pix_ready = 1'b0;
        stall++;
      end else if (mode == 2) begin
        pix_ready = 1'($urandom_range(0, 1));
      end else begin
        pix_ready = 1'b1;
      end
      if (poke_busy && cyc == 4) start = 1'b1;
      #1;
      chk($sformatf("done c%0d", cyc), 32'(done), 32'(exp_done));
      if (exp_done) begin
        finished = 1'b1;
        if (poke_done) start = 1'b1;
      end else begin
        if (hold)
          chk($sformatf("hold c%0d", cyc), 32'({pix_valid, R, G, B, sof, eol, eof}), 32'(held));
        if (pix_valid && first_v < 0) first_v = cyc;
        if (mem_rd) begin
          chk($sformatf("addr %0d", nrd), 32'(mem_addr), 32'(BASE + nrd));
          nrd++;
        end
        if (pix_valid && pix_ready) begin
          chk($sformatf("R px%0d", k), 32'(R), 32'(vt[vb + k].r));
          chk($sformatf("G px%0d", k), 32'(G), 32'(vt[vb + k].g));
          chk($sformatf("B px%0d", k), 32'(B), 32'(vt[vb + k].b));
          chk($sformatf("tags px%0d", k), 32'({sof, eol, eof}),
              32'({vt[vb + k].sof, vt[vb + k].eol, vt[vb + k].eof}));
          exp_done = eof;
          k++;
        end
        chk("outstanding", 32'((nrd - k) <= 2), 32'd1);
        hold = pix_valid && !pix_ready;
        held = {pix_valid, R, G, B, sof, eol, eof};
        @(negedge clk);
      end
    end
    chk("frame completed", 32'(finished), 32'd1);
    chk("pixel count", 32'(k), 32'(NP));
    chk("read count", 32'(nrd), 32'(NP));
    chk("latency", 32'(first_v), 32'd3);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("idle after done", 32'({busy, done}), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("no spurious read", 32'({busy, mem_rd, pix_valid}), 32'd0);
    end
  endtask

  initial begin
    set_v(0, 16'h0000, 8'h00, 8'h00, 8'h00);
    set_v(1, 16'h1111, 8'h10, 8'h20, 8'h8C);
    set_v(2, 16'h2222, 8'h21, 8'h45, 8'h10);
    set_v(3, 16'h3333, 8'h31, 8'h65, 8'h9C);
    set_v(4, 16'h4444, 8'h42, 8'h8A, 8'h21);
    set_v(5, 16'h5555, 8'h52, 8'hAA, 8'hAD);
    set_v(6, 16'h6666, 8'h63, 8'hCF, 8'h31);
    set_v(7, 16'h7777, 8'h73, 8'hEF, 8'hBD);
    set_v(8,  16'hF800, 8'hFF, 8'h00, 8'h00);
    set_v(9,  16'h0841, 8'h08, 8'h08, 8'h08);
    set_v(10, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF);
    set_v(11, 16'h001F, 8'h00, 8'h00, 8'hFF);
    set_v(12, 16'h07E0, 8'h00, 8'hFF, 8'h00);
    set_v(13, 16'h0000, 8'h00, 8'h00, 8'h00);
    set_v(14, 16'hFFE0, 8'hFF, 8'hFF, 8'h00);
    set_v(15, 16'hF81F, 8'hFF, 8'h00, 8'hFF);
    for (int i = 0; i < NP; i++) mem_img[i] = 16'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset ctrl", 32'({busy, done, mem_rd, pix_valid, sof, eol, eof}), 32'd0);
    chk("reset rgb", 32'({R, G, B}), 32'd0);
    chk("reset addr", 32'(mem_addr), 32'(BASE));
    rst_n = 1'b1;

    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(8, 0, 1'b0, 1'b1);
    run_frame(0, 1, 1'b1, 1'b0);
    run_frame(8, 0, 1'b0, 1'b0);

    // Abort mid-frame with a one-cycle reset after pixel 3 is accepted.
    begin
      int k = 0;
      int cyc = 0;
      for (int i = 0; i < NP; i++) mem_img[i] = vt[i].w;
      @(negedge clk);
      start = 1'b1;
      pix_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (k < 4 && cyc < 50) begin
        #1;
        if (pix_valid && pix_ready) k++;
        cyc++;
        @(negedge clk);
      end
      chk("abort reached px3", 32'(k), 32'd4);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("abort ctrl", 32'({busy, done, mem_rd, pix_valid, sof, eol, eof}), 32'd0);
      chk("abort rgb", 32'({R, G, B}), 32'd0);
      chk("abort addr", 32'(mem_addr), 32'(BASE));
      rst_n = 1'b1;
      repeat (6) begin
        @(negedge clk);
        #1;
        chk("abort silent", 32'({busy, done, pix_valid}), 32'd0);
      end
    end
    run_frame(0, 0, 1'b0, 1'b0);

    repeat (3) run_frame(0, 2, 1'b0, 1'b0);
    run_frame(8, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
